instr_sequencer: RTL and testbench

Instruction-issuing front end for the 16-bit register-file/ALU processor core. A host loads a short program byte by byte. On a start pulse, the block issues one 16-bit instruction per clock onto the core's instruction bus. It captures the core's 8-bit result and zero flag for every instruction into a result buffer, which the host reads back after completion.

---
 rtl/instr_sequencer.sv | 177 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Front end that feeds a small register-file/ALU core. The host streams a
//   program in byte by byte (low byte first). A start pulse issues one 16-bit
//   word per clock on inst_out. The core's {zero, result} for each word is
//   captured into a result buffer, which the host reads back once in DONE.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   clear                  synchronous flush back to IDLE; beats every other input
//   load_valid/byte/ready  program byte stream (accepted on valid & ready)
//   start                  begin execution of the loaded program
//   inst_out/inst_valid    registered instruction bus towards the core
//   res_in/zero_in         core result and zero flag for the current inst_out
//   busy/done              state is RUN / state is DONE
//   prog_len               number of complete words loaded (0..DEPTH)
//   rd_en/rd_data/rd_valid result readback, one-cycle latency
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int          DEPTH = 8,
    parameter int          AW    = 3,
    parameter logic [15:0] NOP   = 16'h0004
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load_valid,
    input  logic [7:0]    load_byte,
    output logic          load_ready,
    input  logic          start,
    output logic [15:0]   inst_out,
    output logic          inst_valid,
    input  logic [7:0]    res_in,
    input  logic          zero_in,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   prog_len,
    input  logic          rd_en,
    output logic [8:0]    rd_data,
    output logic          rd_valid
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Storage: not reset, contents only meaningful below prog_len.
    logic [15:0] prog_mem [DEPTH];
    logic [8:0]  res_mem  [DEPTH];

    state_t        state_q, state_d;
    logic [AW:0]   prog_len_q, prog_len_d;
    logic          phase_q, phase_d;
    logic [7:0]    lo_q, lo_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   inst_q, inst_d;
    logic          ivld_q, ivld_d;
    logic [8:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    logic          pw_en, rw_en;
    logic          start_ok, run_last, rd_last;
    logic [AW-1:0] pc_nxt;

    assign load_ready = (state_q != S_RUN) && (prog_len_q < LEN_FULL);
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign prog_len   = prog_len_q;
    assign inst_out   = inst_q;
    assign inst_valid = ivld_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;

    // A half-loaded word blocks start so the program never runs with a
    // dangling low byte.
    assign start_ok = start && (state_q != S_RUN) && (prog_len_q != '0) && !phase_q;
    assign pc_nxt   = pc_q + PTR_ONE;
    assign run_last = ({1'b0, pc_q} == (prog_len_q - LEN_ONE));
    assign rd_last  = ({1'b0, rd_ptr_q} == (prog_len_q - LEN_ONE));

    always_comb begin
        state_d    = state_q;
        prog_len_d = prog_len_q;
        phase_d    = phase_q;
        lo_d       = lo_q;
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        inst_d     = inst_q;
        ivld_d     = ivld_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        pw_en      = 1'b0;
        rw_en      = 1'b0;

        if (clear) begin
            state_d    = S_IDLE;
            prog_len_d = '0;
            phase_d    = 1'b0;
            pc_d       = '0;
            rd_ptr_d   = '0;
            inst_d     = NOP;
            ivld_d     = 1'b0;
            rd_data_d  = '0;
        end else if (state_q == S_RUN) begin
            // inst_q holds prog_mem[pc_q] this cycle; the core answers
            // combinationally, so capture now and present the next word.
            rw_en = 1'b1;
            pc_d  = pc_nxt;
            if (run_last) begin
                state_d = S_DONE;
                inst_d  = NOP;
                ivld_d  = 1'b0;
            end else begin
                inst_d = prog_mem[pc_nxt];
            end
        end else if (start_ok) begin
            state_d  = S_RUN;
            pc_d     = '0;
            rd_ptr_d = '0;
            inst_d   = prog_mem[0];
            ivld_d   = 1'b1;
        end else begin
            if (load_valid && load_ready) begin
                if (!phase_q) begin
                    lo_d    = load_byte;
                    phase_d = 1'b1;
                end else begin
                    pw_en      = 1'b1;
                    prog_len_d = prog_len_q + LEN_ONE;
                    phase_d    = 1'b0;
                end
                // Touching the program invalidates the result buffer view.
                state_d = S_IDLE;
            end
            if (state_q == S_DONE && rd_en) begin
                rd_data_d  = res_mem[rd_ptr_q];
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_last ? '0 : rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            prog_len_q <= '0;
            phase_q    <= 1'b0;
            lo_q       <= '0;
            pc_q       <= '0;
            rd_ptr_q   <= '0;
            inst_q     <= NOP;
            ivld_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_len_q <= prog_len_d;
            phase_q    <= phase_d;
            lo_q       <= lo_d;
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            inst_q     <= inst_d;
            ivld_q     <= ivld_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pw_en) prog_mem[prog_len_q[AW-1:0]] <= {load_byte, lo_q};
        if (rw_en) res_mem[pc_q]                <= {zero_in, res_in};
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
    localparam int          DEPTH = 8;
    localparam int          AW    = 3;
    localparam logic [15:0] NOP   = 16'h0004;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          load_ready;
    logic          start;
    logic [15:0]   inst_out;
    logic          inst_valid;
    logic [7:0]    res_in;
    logic          zero_in;
    logic          busy;
    logic          done;
    logic [AW:0]   prog_len;
    logic          rd_en;
    logic [8:0]    rd_data;
    logic          rd_valid;

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .load_valid(load_valid), .load_byte(load_byte), .load_ready(load_ready),
        .start(start), .inst_out(inst_out), .inst_valid(inst_valid),
        .res_in(res_in), .zero_in(zero_in), .busy(busy), .done(done),
        .prog_len(prog_len), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    // Core stand-in: NOP yields 0, anything else yields low^high byte.
    always_comb begin
        res_in  = (inst_out == NOP) ? 8'h00 : (inst_out[7:0] ^ inst_out[15:8]);
        zero_in = (res_in == 8'h00);
    end

    int tests = 0;
    int fails = 0;

    logic [15:0] prog_q[$];   // model of the loaded program
    int          rptr;        // model of the readback pointer

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_entry(input logic [15:0] w);
        logic [7:0] r;
        r = (w == NOP) ? 8'h00 : (w[7:0] ^ w[15:8]);
        return {(r == 8'h00), r};
    endfunction

    // All tasks enter and leave just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] w);
        send_byte(w[7:0]);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
        send_byte(w[15:8]);
        prog_q.push_back(w);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        prog_q.delete();
        rptr = 0;
    endtask

    task automatic run_prog(input bit rd_during);
        int n;
        n = prog_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (rd_during) rd_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk("run_inst", 32'(inst_out), 32'(prog_q[k]));
            chk("run_ivld", 32'(inst_valid), 32'd1);
            chk("run_busy", 32'(busy), 32'd1);
            if (rd_during) chk("run_no_rdvalid", 32'(rd_valid), 32'd0);
            @(negedge clk);
        end
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ivld", 32'(inst_valid), 32'd0);
        chk("end_inst_nop", 32'(inst_out), 32'(NOP));
        if (rd_during) chk("end_no_rdvalid", 32'(rd_valid), 32'd0);
        rd_en = 1'b0;
        rptr  = 0;
    endtask

    task automatic read_back(input int n);
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data", 32'(rd_data), 32'(model_entry(prog_q[rptr])));
            rptr = (rptr + 1) % prog_q.size();
        end
        rd_en = 1'b0;
        @(negedge clk);
        chk("rd_valid_drop", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        int          len;
        logic [15:0] w;

        rst_n = 1'b0; clear = 1'b0; load_valid = 1'b0; load_byte = 8'h00;
        start = 1'b0; rd_en = 1'b0; rptr = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_inst", 32'(inst_out), 32'h0004);
        chk("rst_ivld", 32'(inst_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_len", 32'(prog_len), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_rdata", 32'(rd_data), 32'd0);
        chk("rst_rvalid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Start with nothing loaded is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("empty_start_busy", 32'(busy), 32'd0);
        chk("empty_start_done", 32'(done), 32'd0);

        // Directed two-word program
        send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD); send_byte(8'hAB);
        prog_q.push_back(16'h1234); prog_q.push_back(16'hABCD);
        chk("two_len", 32'(prog_len), 32'd2);
        run_prog(1'b0);
        rd_en = 1'b1;
        @(negedge clk); chk("two_rd0", 32'(rd_data), 32'h026);
        @(negedge clk); chk("two_rd1", 32'(rd_data), 32'h066);
        @(negedge clk); chk("two_rd_wrap", 32'(rd_data), 32'h026);
        chk("two_rd_valid", 32'(rd_valid), 32'd1);
        rd_en = 1'b0;
        rptr  = 1;
        @(negedge clk);
        chk("two_rd_drop", 32'(rd_valid), 32'd0);

        // Loading in DONE returns to IDLE and appends
        send_byte(8'h0F);
        chk("done_load_idle", 32'(done), 32'd0);
        chk("done_load_busy", 32'(busy), 32'd0);
        send_byte(8'hF0);
        prog_q.push_back(16'hF00F);
        chk("append_len", 32'(prog_len), 32'd3);
        run_prog(1'b1);
        read_back(4);

        // Randomized programs, some with rd_en held during RUN
        for (int it = 0; it < 6; it++) begin
            do_clear();
            len = $urandom_range(1, DEPTH);
            for (int k = 0; k < len; k++) begin
                w = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: w[15:8] = w[7:0];
                    1: w = NOP;
                    default: ;
                endcase
                load_word(w);
            end
            chk("rand_len", 32'(prog_len), 32'(len));
            run_prog(1'($urandom_range(0, 1)));
            read_back(len + 1);
        end

        // Full buffer
        do_clear();
        for (int k = 0; k < DEPTH; k++) begin
            if (k == DEPTH - 1) chk("full_ready_before", 32'(load_ready), 32'd1);
            load_word(16'($urandom));
        end
        chk("full_ready", 32'(load_ready), 32'd0);
        chk("full_len", 32'(prog_len), 32'd8);
        send_byte(8'hEE);
        chk("full_17th_len", 32'(prog_len), 32'd8);
        chk("full_17th_ready", 32'(load_ready), 32'd0);
        run_prog(1'b0);
        read_back(DEPTH);

        // Start with a half-loaded word is ignored
        do_clear();
        send_byte(8'h5A);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("half_start_busy", 32'(busy), 32'd0);
        chk("half_start_len", 32'(prog_len), 32'd0);
        send_byte(8'hC3);
        prog_q.push_back(16'hC35A);
        chk("half_len", 32'(prog_len), 32'd1);
        run_prog(1'b0);
        read_back(2);

        // clear beats start
        do_clear();
        load_word(16'h1111);
        load_word(16'h2222);
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        prog_q.delete();
        chk("clr_start_busy", 32'(busy), 32'd0);
        chk("clr_start_len", 32'(prog_len), 32'd0);
        chk("clr_start_ivld", 32'(inst_valid), 32'd0);

        // Core integration: NOPs give zero results with zero flag set
        load_word(16'h0004);
        load_word(16'h0004);
        run_prog(1'b0);
        rd_en = 1'b1;
        @(negedge clk); chk("nop_rd0", 32'(rd_data), 32'h100);
        @(negedge clk); chk("nop_rd1", 32'(rd_data), 32'h100);
        rd_en = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of RUN
        do_clear();
        load_word(16'h1357); load_word(16'h2468); load_word(16'h9ABC);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_run_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_inst", 32'(inst_out), 32'h0004);
        chk("arst_ivld", 32'(inst_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_len", 32'(prog_len), 32'd0);
        chk("arst_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        chk("arst_hold_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
